// File: rtl/signal_pkg.sv
// Shared constants and types for the signal-head lamp driver.
package signal_pkg;

  localparam logic [1:0] CODE_DARK    = 2'd0;
  localparam logic [1:0] CODE_GO      = 2'd1;
  localparam logic [1:0] CODE_CAUTION = 2'd2;
  localparam logic [1:0] CODE_STOP    = 2'd3;

  // Layout of one MIX byte inside the packed word.
  localparam int CODE_LSB  = 0;
  localparam int FLASH_BIT = 2;
  localparam int BYTE_W    = 6;

  typedef enum logic [2:0] {
    ST_DARK,
    ST_GO,
    ST_CAUTION,
    ST_STOP,
    ST_FORCED
  } head_state_t;

  // Plain (unforced) state that a lamp code asks for.
  function automatic head_state_t code_to_state(input logic [1:0] code);
    head_state_t st;
    case (code)
      CODE_GO:      st = ST_GO;
      CODE_CAUTION: st = ST_CAUTION;
      CODE_STOP:    st = ST_STOP;
      default:      st = ST_DARK;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/signal_heads_if.sv
// Bus between the MIX CPU side and the lamp-driver peripheral.
interface signal_heads_if
  import signal_pkg::*;
#(
  parameter int CHANNELS = 4
) ();

  logic [BYTE_W*CHANNELS-1:0] word;
  logic [3*CHANNELS-1:0]      lamp;
  logic [CHANNELS-1:0]        forcing;
  logic                       button;
  logic                       press;
  logic                       request;
  logic                       ack;

  modport master (
    output word, button, ack,
    input  lamp, forcing, press, request
  );

  modport slave (
    input  word, button, ack,
    output lamp, forcing, press, request
  );

endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle pulse on each
// debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE = 250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [DW-1:0] cnt_q;

  // Synchronise, count consecutive samples that differ from the debounced
  // level, and flip the level once the run reaches DEBOUNCE samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_TC) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/signal_heads.sv
// Lamp driver: per-channel head FSMs with enforced amber on vehicle heads,
// a shared blink divider and the debounced push-button request flag.
//
// state      | meaning
// ST_DARK    | all lamps off
// ST_GO      | green / walk
// ST_CAUTION | amber / don't-walk, may blink when flash is set
// ST_STOP    | red
// ST_FORCED  | vehicle head holding amber for MIN_AMBER cycles
module signal_heads
  import signal_pkg::*;
#(
  parameter int                  CHANNELS     = 4,
  parameter logic [CHANNELS-1:0] VEHICLE_MASK = 4'b0011,
  parameter int                  MIN_AMBER    = 3_000_000,
  parameter int                  BLINK_HALF   = 6_000_000,
  parameter int                  DEBOUNCE     = 250_000
) (
  input  logic          clk,
  input  logic          reset,
  signal_heads_if.slave bus
);

  localparam int AW = $clog2(MIN_AMBER + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [AW-1:0] AMBER_LOAD = AW'(MIN_AMBER - 1);
  localparam logic [BW-1:0] BLINK_TC   = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          press_q;
  logic          request_q;

  // Next blink count and phase; the lamps are registered against the phase
  // that will be current after this edge so they stay in step with it.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Blink divider register; the phase starts lit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .button(bus.button),
    .press (press_q)
  );

  // Sticky request: a press sets it and beats a simultaneous ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) request_q <= 1'b0;
    else        request_q <= press_q | (request_q & ~bus.ack);
  end

  assign bus.press   = press_q;
  assign bus.request = request_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam bit IS_VEHICLE = VEHICLE_MASK[k];

    logic [1:0]    code;
    logic          flash;
    logic          unused_hi;
    head_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [2:0]    lamp_q, lamp_d;
    logic          forcing_q, forcing_d;

    assign code      = bus.word[k*BYTE_W + CODE_LSB +: 2];
    assign flash     = bus.word[k*BYTE_W + FLASH_BIT];
    assign unused_hi = ^bus.word[k*BYTE_W + 3 +: 3];

    // State, hold counter and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= ST_DARK;
        cnt_q     <= '0;
        lamp_q    <= '0;
        forcing_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        lamp_q    <= lamp_d;
        forcing_q <= forcing_d;
      end
    end

    // Follow the code, except a vehicle head leaving GO for STOP/DARK must
    // first hold amber; the code is only re-read when the hold expires.
    always_comb begin
      state_d = code_to_state(code);
      cnt_d   = cnt_q;
      case (state_q)
        ST_FORCED: begin
          if (cnt_q != '0) begin
            state_d = ST_FORCED;
            cnt_d   = cnt_q - 1'b1;
          end
        end
        ST_GO: begin
          if (IS_VEHICLE && (code == CODE_STOP || code == CODE_DARK)) begin
            state_d = ST_FORCED;
            cnt_d   = AMBER_LOAD;
          end
        end
        default: ;
      endcase
    end

    // Lamp decode of the next state; only plain CAUTION honours flash.
    always_comb begin
      lamp_d    = 3'b000;
      forcing_d = (state_d == ST_FORCED);
      case (state_d)
        ST_GO:      lamp_d = 3'b001;
        ST_CAUTION: lamp_d = {1'b0, ~flash | blink_d, 1'b0};
        ST_STOP:    lamp_d = 3'b100;
        ST_FORCED:  lamp_d = 3'b010;
        default:    lamp_d = 3'b000;
      endcase
    end

    assign bus.lamp[3*k +: 3] = lamp_q;
    assign bus.forcing[k]     = forcing_q;
  end

endmodule

// File: doc/signal_heads.md
# signal_heads

Parametrised lamp-driver peripheral for the MIX traffic-signal build. It decodes one 2-bit lamp code per channel from a byte-packed MIX word (normally register X) into registered one-hot lamp drives. It enforces a minimum amber phase on vehicle heads, blinks flashing heads from a shared divider, and debounces the push button into a sticky request for the CPU overflow toggle.

## Interface
Parameters:
- CHANNELS, 4, number of signal heads (1..5); channel k uses byte k of `word`
- VEHICLE_MASK, 4'b0011, bit k = 1 makes channel k a vehicle head (amber enforced); 0 = pedestrian head
- MIN_AMBER, 3_000_000, cycles a forced amber is held (≥1)
- BLINK_HALF, 6_000_000, cycles per blink half-period (≥1)
- DEBOUNCE, 250_000, cycles the synchronised button must be stable (≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- word  in  6*CHANNELS  byte-packed codes; byte k bits [1:0] = code, bit [2] = flash enable, bits [5:3] ignored
- lamp  out  3*CHANNELS  per channel {red, amber, green}, one-hot or all-zero
- forcing  out  CHANNELS  bit k high while channel k holds an enforced amber
- button  in  1  raw asynchronous push button, active-high
- press  out  1  one-cycle pulse on each debounced press
- request  out  1  sticky press flag, feeds the overflow toggle
- ack  in  1  clears `request`

## Operation
- Codes are 0 DARK, 1 GO (green/walk), 2 CAUTION (amber/don't-walk), 3 STOP (red).
- Each channel runs an FSM with states DARK, GO, CAUTION, STOP and FORCED. Every cycle the state follows the requested code, except as below.
- Vehicle head in GO with a request for STOP or DARK: the head enters FORCED, loads a counter with MIN_AMBER-1 and shows amber. It decrements to 0, then leaves for the code requested on the cycle of exit. If that code is GO, it returns to GO.
- FORCED is not re-entered from CAUTION. GO→CAUTION→STOP in software is honoured as-is.
- Pedestrian heads never force. Every code change takes effect directly.
- Lamp mapping: GO→green, CAUTION and FORCED→amber, STOP→red, DARK→none.
- Flash: if bit 2 of the byte is set and the state is CAUTION, amber is gated by the blink phase. Flash is ignored in FORCED, GO and STOP.
- Blink divider: a single counter for all channels. The phase toggles every BLINK_HALF cycles and is 1 (lit) after reset.
- Button path:
  - 2-FF synchroniser, then a stability counter. The debounced level updates only after DEBOUNCE consecutive equal samples.
  - A 0→1 change of the debounced level gives `press` for one cycle and sets `request`.
  - `ack` clears `request`. A press and `ack` in the same cycle leaves `request` = 1 (set wins).

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - FSMs DARK; `lamp` all 0; `forcing` 0.
  - Counters 0; blink phase 1.
  - Synchroniser and debounced level 0; `press` 0; `request` 0.
- `lamp` and `forcing` are registered: a change on `word` is visible exactly 1 cycle later.
- Forced amber on a vehicle head lasts exactly MIN_AMBER cycles of `forcing` = 1. The red lamp appears on the following cycle.
- Changes to `word` during FORCED are ignored until exit. Only the code present on the exit cycle matters.
- Button latency: `press` asserts DEBOUNCE+2 cycles after a clean rising edge. Bounces shorter than DEBOUNCE produce no pulse.
- Reset asserted mid-FORCED or mid-debounce aborts it. No pulse and no lamp is generated on release.
- Counters use the minimum width to hold each parameter value. No wrap occurs: each counter reloads at terminal count.

## Structure
- Package `signal_pkg`:
  - lamp code constants (CODE_DARK/GO/CAUTION/STOP)
  - the channel state enum
  - the byte layout constants (CODE_LSB=0, FLASH_BIT=2, BYTE_W=6)
- Sub-module `button_debounce`: synchroniser, stability counter, edge pulse; parameter DEBOUNCE.
- Per-channel FSMs come from a generate loop in `signal_heads`.

## Test plan
- Reset, then `word` with byte0 = 1 and byte1 = 3 → 1 cycle later lamp[2:0] = 001 and lamp[5:3] = 100; all other channels 000.
- Vehicle ch0 in GO, byte0 set to 3, MIN_AMBER = 4 → amber and forcing[0] for exactly 4 cycles, then red. Pedestrian ch2 given the same sequence goes green→red in 1 cycle.
- Vehicle ch0 in FORCED, `word` toggled 3→1→3 during the hold → amber is held the full 4 cycles, then red.
- byte2 = 6'b000110, BLINK_HALF = 3 → amber on 3 cycles, off 3 cycles, repeating. Flash bit with code 1 → steady green.
- DEBOUNCE = 8, button bouncing 5-cycle pulses, then held high → one `press` at cycle 10 of the stable level; `request` = 1 until `ack`. Press coincident with `ack` → `request` stays 1.
- Assert reset mid-FORCED and mid-debounce → all outputs 0 at once. After release, blink phase is 1 and no spurious `press`.
